// File: rtl/cache_mem_arbiter.sv
// Shares one RAM port between a single-word icache and a WORDS-beat dcache burst engine.
// Grant is registered (one IDLE cycle between transfers); RAM wait/data are routed combinationally.
module cache_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WORDS      = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic [1:0]        gnt,
    output logic              err
);

    localparam int BEAT_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(WORDS - 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
    localparam logic [1:0]          RAM_ACCESS = 2'd2;
    localparam logic [1:0]          RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_XFER = 2'd1,
        D_XFER = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                err_q, err_d;

    logic access;
    logic dreq;

    assign access = (ramstate == RAM_ACCESS);
    assign dreq   = dREN | dWEN;
    assign err    = err_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        starve_d = starve_q;
        err_d    = err_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iload    = '0;
        dload    = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        gnt      = 2'b00;

        case (state_q)
            IDLE: begin
                // dcache has priority unless the icache has been passed over too often
                if (dreq && !(iREN && (starve_q == STARVE_LIM))) begin
                    state_d = D_XFER;
                end else if (iREN) begin
                    state_d = I_XFER;
                end
            end

            I_XFER: begin
                gnt     = 2'b01;
                ramREN  = iREN;
                ramaddr = iaddr;
                iload   = ramload;
                iwait   = ~access;
                if (ramstate == RAM_ERROR) begin
                    err_d = 1'b1;
                end
                if (access) begin
                    state_d  = IDLE;
                    starve_d = '0;
                end else if (!iREN) begin
                    state_d = IDLE;
                end
            end

            D_XFER: begin
                gnt      = 2'b10;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dload    = ramload;
                dwait    = ~access;
                if (ramstate == RAM_ERROR) begin
                    err_d = 1'b1;
                end
                if (!dreq) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end else if (access) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                        beat_d  = '0;
                        if (!iREN) begin
                            starve_d = '0;
                        end else if (starve_q != STARVE_LIM) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios with literal expectations, then randomized
// icache/dcache traffic compared every cycle against a transaction-level ownership model.
module tb_cache_mem_arbiter;

    localparam int WORDS      = 2;
    localparam int STARVE_MAX = 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload = '0;
    logic [1:0]  ramstate = 2'd1;
    logic [1:0]  gnt;
    logic        err;

    int tests = 0;
    int fails = 0;

    cache_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .WORDS(WORDS), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .gnt(gnt), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Ownership model: who holds the RAM, how many beats of the current burst are done,
    // how many dcache bursts have gone by while the icache was waiting, sticky error.
    int m_owner = 0;     // 0 nobody, 1 icache, 2 dcache
    int m_done  = 0;
    int m_skip  = 0;
    bit m_err   = 1'b0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_owner = 0; m_done = 0; m_skip = 0; m_err = 1'b0;
        end else if (m_owner == 0) begin
            if ((dREN || dWEN) && !(iREN && m_skip >= STARVE_MAX)) m_owner = 2;
            else if (iREN) m_owner = 1;
        end else if (m_owner == 1) begin
            if (ramstate == 2'd3) m_err = 1'b1;
            if (ramstate == 2'd2) begin
                m_owner = 0;
                m_skip  = 0;
            end else if (!iREN) begin
                m_owner = 0;
            end
        end else begin
            if (ramstate == 2'd3) m_err = 1'b1;
            if (!(dREN || dWEN)) begin
                m_owner = 0;
                m_done  = 0;
            end else if (ramstate == 2'd2) begin
                m_done = m_done + 1;
                if (m_done == WORDS) begin
                    m_owner = 0;
                    m_done  = 0;
                    m_skip  = iREN ? ((m_skip + 1 > STARVE_MAX) ? STARVE_MAX : m_skip + 1) : 0;
                end
            end
        end
    end

    logic [1:0]  e_gnt;
    logic        e_ramREN, e_ramWEN, e_iwait, e_dwait;
    logic [31:0] e_ramaddr, e_ramstore, e_iload, e_dload;

    always @(negedge CLK) begin
        e_gnt = 2'(m_owner);
        e_ramREN = 1'b0; e_ramWEN = 1'b0; e_ramaddr = '0; e_ramstore = '0;
        e_iload = '0; e_dload = '0; e_iwait = 1'b1; e_dwait = 1'b1;
        if (m_owner == 1) begin
            e_ramREN = iREN; e_ramaddr = iaddr; e_iload = ramload;
            e_iwait = (ramstate != 2'd2);
        end else if (m_owner == 2) begin
            e_ramWEN = dWEN; e_ramREN = dREN && !dWEN; e_ramaddr = daddr;
            e_ramstore = dstore; e_dload = ramload;
            e_dwait = (ramstate != 2'd2);
        end
        chk("m_gnt", gnt, e_gnt);
        chk("m_ramREN", ramREN, e_ramREN);
        chk("m_ramWEN", ramWEN, e_ramWEN);
        chk("m_ramaddr", ramaddr, e_ramaddr);
        chk("m_ramstore", ramstore, e_ramstore);
        chk("m_iload", iload, e_iload);
        chk("m_dload", dload, e_dload);
        chk("m_iwait", iwait, e_iwait);
        chk("m_dwait", dwait, e_dwait);
        chk("m_err", err, m_err);
    end

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL watchdog: simulation did not complete, expected finish before 1ms");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    int seq5 [8] = '{2, 2, 3, 3, 2, 1, 1, 1};

    initial begin
        int nb, prev, after, beats, last_cyc;
        bit got_i;
        logic [31:0] beat_addr;
        bit i_done, d_done;
        int d_left;

        #1 RST = 1'b1;
        tick(); tick();
        @(negedge CLK);
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_iwait", iwait, 1'b1);
        chk("rst_dwait", dwait, 1'b1);
        chk("rst_strobes", {ramREN, ramWEN}, 2'b00);
        chk("rst_err", err, 1'b0);
        tick();
        RST = 1'b0;

        // 1: single icache read, ACCESS on the second strobe cycle
        iREN = 1'b1; iaddr = 32'h40; ramstate = 2'd1; ramload = 32'hDEADBEEF;
        @(negedge CLK); chk("t1_idle_gnt", gnt, 2'b00);
        tick();
        @(negedge CLK);
        chk("t1_gnt", gnt, 2'b01);
        chk("t1_ramREN", ramREN, 1'b1);
        chk("t1_ramaddr", ramaddr, 32'h40);
        chk("t1_iwait_busy", iwait, 1'b1);
        tick(); ramstate = 2'd2;
        @(negedge CLK);
        chk("t1_iwait", iwait, 1'b0);
        chk("t1_iload", iload, 32'hDEADBEEF);
        tick(); iREN = 1'b0; ramstate = 2'd1;
        @(negedge CLK); chk("t1_back_idle", gnt, 2'b00);

        // 2: dcache write burst
        dWEN = 1'b1; daddr = 32'h100; dstore = 32'hA; ramstate = 2'd2;
        tick();
        @(negedge CLK);
        chk("t2_gnt0", gnt, 2'b10);
        chk("t2_wen0", ramWEN, 1'b1);
        chk("t2_addr0", ramaddr, 32'h100);
        chk("t2_store0", ramstore, 32'hA);
        chk("t2_iwait0", iwait, 1'b1);
        tick(); daddr = 32'h104; dstore = 32'hB;
        @(negedge CLK);
        chk("t2_gnt1", gnt, 2'b10);
        chk("t2_wen1", ramWEN, 1'b1);
        chk("t2_addr1", ramaddr, 32'h104);
        chk("t2_store1", ramstore, 32'hB);
        tick(); dWEN = 1'b0;
        @(negedge CLK); chk("t2_end", gnt, 2'b00);

        // 3: simultaneous requests, dcache first, one IDLE cycle, then icache
        tick(); iREN = 1'b1; dREN = 1'b1; daddr = 32'h200; ramstate = 2'd2;
        @(negedge CLK); chk("t3_idle", gnt, 2'b00);
        tick();
        @(negedge CLK); chk("t3_d_first", gnt, 2'b10); chk("t3_iwait", iwait, 1'b1);
        tick(); daddr = 32'h204;
        @(negedge CLK); chk("t3_d_beat1", gnt, 2'b10);
        tick(); dREN = 1'b0;
        @(negedge CLK); chk("t3_gap", gnt, 2'b00);
        tick();
        @(negedge CLK); chk("t3_i_gnt", gnt, 2'b01); chk("t3_i_done", iwait, 1'b0);
        tick(); iREN = 1'b0;
        @(negedge CLK); chk("t3_end", gnt, 2'b00);

        // 4: starvation bound with both requesters held
        tick(); iREN = 1'b1; dREN = 1'b1; ramstate = 2'd2;
        nb = 0; prev = 0; got_i = 1'b0; after = -1;
        for (int c = 0; c < 40 && after < 0; c++) begin
            @(negedge CLK);
            if (gnt == 2'b10 && prev == 0 && !got_i) nb++;
            if (gnt == 2'b01) got_i = 1'b1;
            if (got_i && gnt == 2'b10) after = 2;
            prev = int'(gnt);
            tick();
        end
        chk("t4_bursts_before_i", nb, 3);
        chk("t4_i_granted", got_i, 1'b1);
        chk("t4_d_after_reset_starve", after, 2);
        iREN = 1'b0; dREN = 1'b0;
        tick(); tick();

        // 5: ERROR stalls the burst, err is sticky, burst still completes with WORDS beats
        dREN = 1'b1; daddr = 32'h300;
        beats = 0; last_cyc = -1; beat_addr = '0;
        for (int c = 0; c < 8; c++) begin
            ramstate = 2'(seq5[c]);
            @(negedge CLK);
            d_done = (gnt == 2'b10) && !dwait;
            if (d_done) begin beats++; last_cyc = c; beat_addr = ramaddr; end
            if (c == 1) chk("t5_err_before", err, 1'b0);
            if (c == 3) chk("t5_err_set", err, 1'b1);
            tick();
            if (d_done) begin
                daddr = daddr + 4;
                if (beats == WORDS) dREN = 1'b0;
            end
        end
        chk("t5_beats", beats, WORDS);
        chk("t5_last_beat_cycle", last_cyc, 4);
        chk("t5_last_addr", beat_addr, 32'h304);
        chk("t5_err_sticky", err, 1'b1);

        // 6: reset during beat 1 of a read burst
        dREN = 1'b1; daddr = 32'h400; ramstate = 2'd2;
        tick();
        @(negedge CLK); chk("t6_beat0", {ramREN, dwait}, 2'b10);
        tick(); daddr = 32'h404; ramstate = 2'd1;
        #1 RST = 1'b1;
        #1;
        chk("t6_rst_gnt", gnt, 2'b00);
        chk("t6_rst_ren", ramREN, 1'b0);
        chk("t6_rst_dwait", dwait, 1'b1);
        chk("t6_rst_err", err, 1'b0);
        tick(); RST = 1'b0; daddr = 32'h400;
        @(negedge CLK); chk("t6_no_strobe", {gnt, ramREN}, 3'b000);
        tick(); ramstate = 2'd2;
        @(negedge CLK); chk("t6_restart_addr", ramaddr, 32'h400); chk("t6_restart_gnt", gnt, 2'b10);
        tick(); daddr = 32'h404;
        @(negedge CLK); chk("t6_beat1_addr", ramaddr, 32'h404); chk("t6_beat1_dwait", dwait, 1'b0);
        tick(); dREN = 1'b0;
        @(negedge CLK); chk("t6_done", gnt, 2'b00);

        // Random traffic; the per-cycle compare process does the checking
        tick();
        d_left = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            i_done = iREN && !iwait;
            d_done = (dREN || dWEN) && !dwait;
            tick();
            if ($urandom_range(0, 599) == 0) begin
                RST = 1'b1;
                iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; d_left = 0;
                tick();
                RST = 1'b0;
                continue;
            end
            ramload = $urandom();
            case ($urandom_range(0, 19))
                0, 1, 2:  ramstate = 2'd1;
                3:        ramstate = 2'd0;
                4:        ramstate = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'd1;
                default:  ramstate = 2'd2;
            endcase
            if (i_done) iREN = 1'b0;
            else if (iREN && $urandom_range(0, 49) == 0) iREN = 1'b0;
            if (!iREN && $urandom_range(0, 2) == 0) begin
                iREN = 1'b1;
                iaddr = $urandom() & 32'hFFFF_FFFC;
            end
            if (d_done) begin
                d_left--;
                daddr = daddr + 4;
                dstore = $urandom();
                if (d_left == 0) begin dREN = 1'b0; dWEN = 1'b0; end
            end
            if (d_left == 0 && $urandom_range(0, 2) == 0) begin
                d_left = WORDS;
                daddr = $urandom() & 32'hFFFF_FFF8;
                dstore = $urandom();
                case ($urandom_range(0, 4))
                    0, 1:    begin dREN = 1'b1; dWEN = 1'b0; end
                    2, 3:    begin dREN = 1'b0; dWEN = 1'b1; end
                    default: begin dREN = 1'b1; dWEN = 1'b1; end
                endcase
            end
        end
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
